pkt_fifo_reader: RTL and testbench
==================================

PKT_FIFO_READER -- requirements
Module: pkt_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, FIFO and stream word width.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, header length field width; LEN_WIDTH SHALL be less than or equal to DATA_WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fifo_dout  input  DATA_WIDTH  FWFT FIFO head word, valid whenever fifo_empty=0.
REQ-006 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-007 SHALL have port fifo_rd_en  output  1  pop request to FIFO.
REQ-008 SHALL have port m_data  output  DATA_WIDTH  stream data.
REQ-009 SHALL have port m_valid  output  1  stream data valid.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port m_sop  output  1  first (header) word of packet.
REQ-012 SHALL have port m_eop  output  1  last word of packet.
REQ-013 SHALL have port len_err  output  1  one-cycle pulse, zero-length header dropped.

Function
REQ-014 SHALL treat the first FIFO word of a packet as header; header[LEN_WIDTH-1:0] = N, the number of payload words that follow.
REQ-015 SHALL hold one registered output word (m_data/m_valid/m_sop/m_eop); a transfer occurs when m_valid and m_ready are both 1.
REQ-016 SHALL drive fifo_rd_en = ~fifo_empty & (~m_valid | m_ready) combinationally; it SHALL never be 1 while fifo_empty=1.
REQ-017 SHALL load fifo_dout into the output register on the clock edge where fifo_rd_en=1, giving 1-cycle latency from FIFO head to m_valid.
REQ-018 SHALL sustain 1 word/cycle when the FIFO is non-empty and m_ready is held at 1.
REQ-019 SHALL hold m_data, m_sop and m_eop stable while m_valid=1 and m_ready=0.
REQ-020 SHALL implement states IDLE (expecting header) and BODY (payload remaining).
REQ-021 In IDLE, on a pop with N>0: SHALL load with m_sop=1, m_eop=0, set remaining counter rem=N, and go to BODY.
REQ-022 In IDLE, on a pop with N=0: SHALL consume the word, set m_valid=0 for that load, pulse len_err for 1 cycle, and stay in IDLE.
REQ-023 In BODY, on each pop: SHALL load with m_sop=0 and decrement rem; when rem==1 it SHALL set m_eop=1 and go to IDLE.
REQ-024 Counter rem SHALL be LEN_WIDTH bits and SHALL never wrap; N=2^LEN_WIDTH-1 SHALL be supported.
REQ-025 A header loaded in the same cycle that the previous eop word transfers SHALL be permitted, with no bubble.
REQ-026 The FIFO running empty mid-packet SHALL stall in BODY with rem preserved; m_valid SHALL drop after the pending word transfers.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately give state=IDLE, rem=0, m_valid=0, m_sop=0, m_eop=0, len_err=0, m_data=0, fifo_rd_en=0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet; after release, the next FIFO word SHALL be treated as a header.

Configuration
REQ-029 Macro PKT_FIFO_READER_STATS_EN defined: SHALL add output pkt_cnt (16 bits, reset 0), incremented on each eop transfer and wrapping 0xFFFF to 0.
REQ-030 Macro PKT_FIFO_READER_STATS_EN undefined: pkt_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package pkt_pkg SHALL hold the state enum (IDLE, BODY) and the header length field LSB/width constants.
REQ-032 The output register plus its handshake SHALL be one sub-module, pkt_out_slice; the FSM and counter SHALL be in pkt_fifo_reader.

Verification
REQ-033 FIFO holds hdr N=3 and payloads A, B, C, with m_ready=1 -> 4 consecutive m_valid cycles; sop on hdr, eop on C, first m_valid 1 cycle after fifo_empty falls.
REQ-034 Same packet with m_ready=0 for 5 cycles on B -> B held stable, fifo_rd_en=0 during the stall, no word lost or duplicated.
REQ-035 Header N=0 followed by hdr N=1 and payload D -> len_err pulses once, nothing emitted for the N=0 header, then hdr(sop) and D(eop).
REQ-036 Back-to-back packets N=1 and N=2 -> 5 words with no bubble; eop word and next header on adjacent cycles.
REQ-037 FIFO empties after hdr N=4 plus 2 payloads, then refills with 2 words -> stall then resume; eop on the 4th payload word.
REQ-038 rst_n pulsed low after 2 payloads of N=5 -> outputs zero asynchronously; the next FIFO word emitted with sop=1. With the stats macro defined, pkt_cnt counts only completed packets.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared types and header-field constants for the packet FIFO reader.
package pkt_pkg;

  // Parser state: IDLE waits for a header word, BODY forwards payload words.
  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_e;

  // Position and default width of the payload length field in a header word.
  localparam int unsigned HDR_LEN_LSB   = 0;
  localparam int unsigned HDR_LEN_WIDTH = 8;

endpackage

// File: rtl/pkt_out_slice.sv
// Single-entry registered output stage with valid/ready handshake.
// Accepts a new word whenever it is empty or its current word is leaving.
module pkt_out_slice #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  can_load_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  sop_q;
  logic                  eop_q;

  assign can_load_o = ~valid_q | ready_i;

  // Output register: load on pop, otherwise clear valid once the word is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= valid_i;
      sop_q   <= sop_i;
      eop_q   <= eop_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;

endmodule

// File: rtl/pkt_fifo_reader.sv
// Reads length-prefixed packets from a FWFT FIFO and emits them as a
// valid/ready stream with sop/eop markers. Zero-length headers are dropped
// with a one-cycle len_err pulse.
// Optional macro PKT_FIFO_READER_STATS_EN adds a 16-bit completed-packet counter.
module pkt_fifo_reader
  import pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = HDR_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  len_err
`ifdef PKT_FIFO_READER_STATS_EN
  ,
  output logic [15:0]           pkt_cnt
`endif
);

  state_e                 state_q;
  logic [LEN_WIDTH-1:0]   rem_q;
  logic [LEN_WIDTH-1:0]   rem_d;
  logic                   len_err_q;

  logic [LEN_WIDTH-1:0]   hdr_len;
  logic                   hdr_nonzero;
  logic                   rem_is_one;
  logic                   can_load;
  logic                   ld_valid;
  logic                   ld_sop;
  logic                   ld_eop;

  assign hdr_len     = fifo_dout[HDR_LEN_LSB +: LEN_WIDTH];
  assign hdr_nonzero = (hdr_len != '0);
  assign rem_is_one  = (rem_q == LEN_WIDTH'(1));
  assign rem_d       = rem_q - LEN_WIDTH'(1);

  // rst_n gates the pop so the FIFO is never touched while reset is held.
  assign fifo_rd_en = rst_n & ~fifo_empty & can_load;

  assign ld_valid = (state_q == BODY) | hdr_nonzero;
  assign ld_sop   = (state_q == IDLE) & hdr_nonzero;
  assign ld_eop   = (state_q == BODY) & rem_is_one;

  // Header/payload parser: tracks remaining payload words and flags empty packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      if (fifo_rd_en) begin
        case (state_q)
          IDLE: begin
            if (hdr_nonzero) begin
              rem_q   <= hdr_len;
              state_q <= BODY;
            end else begin
              len_err_q <= 1'b1;
            end
          end
          BODY: begin
            rem_q <= rem_d;
            if (rem_is_one) begin
              state_q <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign len_err = len_err_q;

  pkt_out_slice #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (fifo_rd_en),
    .data_i     (fifo_dout),
    .valid_i    (ld_valid),
    .sop_i      (ld_sop),
    .eop_i      (ld_eop),
    .ready_i    (m_ready),
    .data_o     (m_data),
    .valid_o    (m_valid),
    .sop_o      (m_sop),
    .eop_o      (m_eop),
    .can_load_o (can_load)
  );

`ifdef PKT_FIFO_READER_STATS_EN
  logic [15:0] pkt_cnt_q;

  // Completed-packet counter, advanced on every eop handshake; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else if (m_valid && m_ready && m_eop) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_fifo_reader.sv
// Self-checking bench for pkt_fifo_reader. Packets are generated at the
// packet level; the expected stream is built alongside the FIFO contents.
module tb_pkt_fifo_reader;

  localparam int DW    = 32;
  localparam int LW    = 8;
  localparam int MEMSZ = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_sop;
  logic          m_eop;
  logic          len_err;
`ifdef PKT_FIFO_READER_STATS_EN
  logic [15:0]   pkt_cnt;
`endif

  always #5 clk = ~clk;

  pkt_fifo_reader #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .len_err    (len_err)
`ifdef PKT_FIFO_READER_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt)
`endif
  );

  // FWFT FIFO model
  logic [DW-1:0] mem [0:MEMSZ-1];
  int unsigned   wr_cnt = 0;
  int unsigned   rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);
  assign fifo_dout  = mem[rd_cnt[11:0]];
  always @(posedge clk) if (fifo_rd_en && !fifo_empty) rd_cnt <= rd_cnt + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    int            cyc;
  } beat_t;

  beat_t obs[$];
  beat_t exp_q[$];

  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_lenerr = 0;
  int len_err_seen = 0;
  int hold_viol = 0;
  int rd_viol = 0;
  int eop_since_rst = 0;

  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_sop, prev_eop;

  // Monitor: samples pre-edge values, i.e. what the DUT sees at this edge.
  always @(posedge clk) begin
    beat_t b;
    if (m_valid && m_ready) begin
      b.d = m_data; b.sop = m_sop; b.eop = m_eop; b.cyc = cyc;
      obs.push_back(b);
    end
    if (len_err) len_err_seen++;
    if (fifo_rd_en && fifo_empty) rd_viol++;
    if (m_valid && !m_ready && fifo_rd_en) rd_viol++;
    if (prev_hold && m_valid && ({m_data, m_sop, m_eop} !== {prev_d, prev_sop, prev_eop})) hold_viol++;
    prev_hold = m_valid && !m_ready && rst_n;
    prev_d = m_data; prev_sop = m_sop; prev_eop = m_eop;
    if (!rst_n) eop_since_rst = 0;
    else if (m_valid && m_ready && m_eop) eop_since_rst++;
  end

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_cnt[11:0]] = w;
    wr_cnt++;
  endtask

  task automatic add_exp(input logic [DW-1:0] d, input logic sop, input logic eop);
    beat_t b;
    b.d = d; b.sop = sop; b.eop = eop; b.cyc = 0;
    exp_q.push_back(b);
  endtask

  task automatic push_packet(input int n);
    logic [DW-1:0] w;
    w = $urandom;
    w[LW-1:0] = n[LW-1:0];
    push_word(w);
    if (n == 0) exp_lenerr++;
    else add_exp(w, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      push_word(w);
      add_exp(w, 1'b0, i == n - 1);
    end
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && obs.size() < exp_q.size(); i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic start_scenario();
    obs.delete();
    exp_q.delete();
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({m_valid, m_sop, m_eop, len_err, fifo_rd_en} !== 5'b0 || m_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b sop=%b eop=%b len_err=%b rd_en=%b data=%h, expected all zero",
               m_valid, m_sop, m_eop, len_err, fifo_rd_en, m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    start_scenario();
    @(negedge clk);
    push_packet(3);
    @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_sop !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got valid=%b sop=%b one cycle after fill, expected valid=1 sop=1", m_valid, m_sop);
    end
    wait_drain(50);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d beats, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].sop !== exp_q[i].sop || obs[i].eop !== exp_q[i].eop) begin
        errors++;
        $display("FAIL basic_beat[%0d]: got d=%h sop=%b eop=%b, expected d=%h sop=%b eop=%b",
                 i, obs[i].d, obs[i].sop, obs[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
      if (i > 0) begin
        checks++;
        if (obs[i].cyc != obs[0].cyc + i) begin
          errors++;
          $display("FAIL basic_gap[%0d]: got cycle %0d, expected %0d", i, obs[i].cyc, obs[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] b_word;
    bit found = 0;
    start_scenario();
    @(negedge clk);
    push_packet(3);
    b_word = exp_q[2].d;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_valid && m_data === b_word) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stall_reach: got no B word within 20 cycles, expected B=%h on m_data", b_word);
    end
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== b_word || m_sop !== 1'b0 || fifo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%h sop=%b rd_en=%b, expected valid=1 data=%h sop=0 rd_en=0",
                 k, m_valid, m_data, m_sop, fifo_rd_en, b_word);
      end
    end
    m_ready = 1'b1;
    wait_drain(50);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d beats, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].sop !== exp_q[i].sop || obs[i].eop !== exp_q[i].eop) begin
        errors++;
        $display("FAIL stall_beat[%0d]: got d=%h sop=%b eop=%b, expected d=%h sop=%b eop=%b",
                 i, obs[i].d, obs[i].sop, obs[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
  endtask

  task automatic test_len_err();
    start_scenario();
    @(negedge clk);
    push_packet(0);
    push_packet(1);
    wait_drain(50);
    checks++;
    if (len_err_seen != exp_lenerr) begin
      errors++;
      $display("FAIL lenerr_pulses: got %0d len_err cycles, expected %0d", len_err_seen, exp_lenerr);
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL lenerr_count: got %0d beats, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].sop !== exp_q[i].sop || obs[i].eop !== exp_q[i].eop) begin
        errors++;
        $display("FAIL lenerr_beat[%0d]: got d=%h sop=%b eop=%b, expected d=%h sop=%b eop=%b",
                 i, obs[i].d, obs[i].sop, obs[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_scenario();
    @(negedge clk);
    push_packet(1);
    push_packet(2);
    wait_drain(50);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d beats, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].sop !== exp_q[i].sop || obs[i].eop !== exp_q[i].eop ||
          obs[i].cyc != obs[0].cyc + i) begin
        errors++;
        $display("FAIL b2b_beat[%0d]: got d=%h sop=%b eop=%b cyc=%0d, expected d=%h sop=%b eop=%b cyc=%0d",
                 i, obs[i].d, obs[i].sop, obs[i].eop, obs[i].cyc,
                 exp_q[i].d, exp_q[i].sop, exp_q[i].eop, obs[0].cyc + i);
      end
    end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] w;
    start_scenario();
    @(negedge clk);
    w = $urandom; w[LW-1:0] = 8'd4;
    push_word(w); add_exp(w, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      w = $urandom; push_word(w); add_exp(w, 1'b0, 1'b0);
    end
    wait_drain(50);
    checks++;
    if (m_valid !== 1'b0 || obs.size() != 3) begin
      errors++;
      $display("FAIL underflow_stall: got valid=%b beats=%0d while FIFO empty, expected valid=0 beats=3", m_valid, obs.size());
    end
    for (int i = 0; i < 2; i++) begin
      w = $urandom; push_word(w); add_exp(w, 1'b0, i == 1);
    end
    wait_drain(50);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL underflow_count: got %0d beats, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].sop !== exp_q[i].sop || obs[i].eop !== exp_q[i].eop) begin
        errors++;
        $display("FAIL underflow_beat[%0d]: got d=%h sop=%b eop=%b, expected d=%h sop=%b eop=%b",
                 i, obs[i].d, obs[i].sop, obs[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    logic [DW-1:0] pay [5];
    bit reached = 0;
    start_scenario();
    @(negedge clk);
    w = $urandom; w[LW-1:0] = 8'd5;
    push_word(w); add_exp(w, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pay[i] = $urandom;
      if (i == 3) pay[i][LW-1:0] = 8'd1;
      push_word(pay[i]);
    end
    add_exp(pay[0], 1'b0, 1'b0);
    add_exp(pay[1], 1'b0, 1'b0);
    // After reset the packet is abandoned: pay[3] is parsed as a header of length 1.
    add_exp(pay[3], 1'b1, 1'b0);
    add_exp(pay[4], 1'b0, 1'b1);
    for (int i = 0; i < 20 && !reached; i++) begin
      @(negedge clk);
      if (obs.size() >= 3) reached = 1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL rstmid_reach: got %0d beats within 20 cycles, expected 3", obs.size());
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_sop, m_eop, len_err, fifo_rd_en} !== 5'b0 || m_data !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got valid=%b sop=%b eop=%b len_err=%b rd_en=%b data=%h, expected all zero",
               m_valid, m_sop, m_eop, len_err, fifo_rd_en, m_data);
    end
`ifdef PKT_FIFO_READER_STATS_EN
    checks++;
    if (pkt_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_pktcnt: got %0d, expected 0", pkt_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain(50);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rstmid_count: got %0d beats, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].sop !== exp_q[i].sop || obs[i].eop !== exp_q[i].eop) begin
        errors++;
        $display("FAIL rstmid_beat[%0d]: got d=%h sop=%b eop=%b, expected d=%h sop=%b eop=%b",
                 i, obs[i].d, obs[i].sop, obs[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
  endtask

  task automatic test_random();
    start_scenario();
    for (int p = 0; p < 12; p++) begin
      push_packet(p == 5 ? 255 : int'($urandom_range(0, 6)));
      for (int g = int'($urandom_range(0, 6)); g > 0; g--) begin
        @(negedge clk);
        m_ready = ($urandom_range(0, 3) != 0);
      end
    end
    for (int i = 0; i < 3000 && obs.size() < exp_q.size(); i++) begin
      @(negedge clk);
      m_ready = ($urandom_range(0, 3) != 0);
    end
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d beats, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].sop !== exp_q[i].sop || obs[i].eop !== exp_q[i].eop) begin
        errors++;
        $display("FAIL random_beat[%0d]: got d=%h sop=%b eop=%b, expected d=%h sop=%b eop=%b",
                 i, obs[i].d, obs[i].sop, obs[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
    checks++;
    if (len_err_seen != exp_lenerr) begin
      errors++;
      $display("FAIL random_lenerr: got %0d len_err cycles, expected %0d", len_err_seen, exp_lenerr);
    end
    checks++;
    if (hold_viol != 0 || rd_viol != 0) begin
      errors++;
      $display("FAIL random_protocol: got %0d hold and %0d pop violations, expected 0 and 0", hold_viol, rd_viol);
    end
`ifdef PKT_FIFO_READER_STATS_EN
    checks++;
    if (pkt_cnt !== eop_since_rst[15:0]) begin
      errors++;
      $display("FAIL random_pktcnt: got %0d, expected %0d", pkt_cnt, eop_since_rst[15:0]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len_err();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t, expected the sequence to finish", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
